ysyx_24090013_ifu: RTL and testbench
====================================

# ysyx_24090013_ifu

Instruction fetch unit placed between the instruction ROM and the decode stage of `ysyx_24090013_openmips`. It owns the program counter and drives the ROM read port. It captures each returned word with its PC into a small FIFO and hands entries to decode over a valid/ready handshake. A redirect input from execute flushes the FIFO and restarts fetch at a new target.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.
- `DEPTH`, default 2: FIFO entries; power of two, at least 2.

Ports (clock and reset first):
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ifu_instrom_addr` output 32: ROM read address; always equals the current PC.
- `ifu_instrom_ren` output 1: ROM read enable, and the push strobe for this cycle.
- `instrom_ifu_data` input 32: ROM read data; combinational, valid in the same cycle as addr/ren.
- `ifu_id_valid` output 1: FIFO head holds a valid entry.
- `ifu_id_inst` output 32: instruction word at the FIFO head.
- `ifu_id_pc` output 32: PC of the FIFO head entry.
- `id_ifu_ready` input 1: decode accepts the head this cycle.
- `ex_ifu_redirect` input 1: flush the FIFO and restart fetch.
- `ex_ifu_target` input 32: redirect target; bits [1:0] are forced to 0.

## Operation
- State:
  - `pc` register, 32 bits.
  - FIFO of DEPTH entries of {pc, inst}.
  - Read pointer and write pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` register, log2(DEPTH)+1 bits.
- `ifu_instrom_ren = !rst && !ex_ifu_redirect && (count < DEPTH)`.
  - ren does not depend on `id_ifu_ready`. A full FIFO does not push even if a pop occurs in the same cycle.
- Push, when ren=1:
  - Write {pc, instrom_ifu_data} at the write pointer; advance the write pointer.
  - Update `pc <= pc + 4`, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Pop, when valid && ready: advance the read pointer.
- `count` update: +1 on push only, −1 on pop only, unchanged on push and pop together.
- Redirect, when ex_ifu_redirect=1 (highest priority):
  - `pc <= {ex_ifu_target[31:2], 2'b00}`.
  - Set count to 0, both pointers to 0.
  - No push occurs in this cycle.
  - If valid && ready coincides with the redirect, that handshake completes: decode has consumed the entry. All other entries are discarded.
- `ifu_id_valid = (count != 0)`, driven from registers only.
- `ifu_id_inst` and `ifu_id_pc` show the FIFO head.
  - While empty, they hold the last head value. They hold 0 after reset.
- When valid=1 and ready=0, the head must stay stable until it is popped or flushed.

## Timing
- Values during and after reset:
  - pc=RESET_PC, count=0, pointers=0, FIFO storage=0.
  - ifu_id_valid=0, ifu_id_inst=0, ifu_id_pc=0, ifu_instrom_ren=0.
  - ifu_instrom_addr=RESET_PC.
- First cycle after rst deasserts: ren=1, addr=RESET_PC. ifu_id_valid rises in the next cycle.
- Fetch-to-decode latency is 1 cycle, measured from the ren cycle to the first cycle valid is seen.
- Throughput with ready held at 1 is 1 instruction per cycle. count settles at 1.
- With ready held at 0, the FIFO fills after DEPTH pushes. ren then stays 0 and the PC is frozen.
- After ready returns to 1:
  - The pop cycle itself still has ren=0, because count==DEPTH.
  - Fetch resumes in the following cycle.
- Redirect in cycle N:
  - Cycle N+1: valid=0, addr=target, ren=1.
  - Cycle N+2: the target entry is valid.
- Redirect held high for several cycles: fetch stays suppressed and pc is reloaded each cycle.
- rst asserted mid-operation: all state clears immediately (asynchronous). Any in-flight entries are lost.

## Test plan
- Reset and stream:
  - Stimulus: ROM returns word = addr ^ 32'hA5A5_A5A5; ready=1.
  - Required: valid rises 1 cycle after reset release; pc sequence 8000_0000, 8000_0004, … one per cycle; each inst matches its pc.
- Backpressure:
  - Stimulus: ready=0 for 5 cycles, then 1.
  - Required: exactly DEPTH pushes, then ren=0; head stays at 8000_0000 throughout; after release, entries drain in order with no PC skipped or duplicated.
- Redirect with queued entries:
  - Stimulus: FIFO full; assert redirect with target 8000_0103 for 1 cycle.
  - Required: next cycle valid=0 and addr=8000_0100; the following cycle head pc=8000_0100.
- Redirect coincident with pop:
  - Stimulus: valid=1, ready=1, redirect=1 in the same cycle.
  - Required: that entry counts as consumed once; no stale entry appears afterwards.
- Wrap-around:
  - Stimulus: redirect to FFFF_FFF8, ready=1.
  - Required: head pcs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Asynchronous reset mid-stream:
  - Stimulus: assert rst between clock edges while the FIFO holds 2 entries.
  - Required: valid drops to 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_24090013_ifu.sv
// Fetch unit: owns the PC, reads the ROM, and queues {pc, inst} for decode. An entry is valid one cycle after its fetch.
// Fetch stalls only while the queue is full (a same-cycle pop does not free a slot); a redirect flushes the queue and reloads the PC.
module ysyx_24090013_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ifu_instrom_addr,
    output logic        ifu_instrom_ren,
    input  logic [31:0] instrom_ifu_data,
    output logic        ifu_id_valid,
    output logic [31:0] ifu_id_inst,
    output logic [31:0] ifu_id_pc,
    input  logic        id_ifu_ready,
    input  logic        ex_ifu_redirect,
    input  logic [31:0] ex_ifu_target
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_pc_d   [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];
    logic [31:0]   mem_inst_d [DEPTH];
    logic [31:0]   hold_pc_q, hold_pc_d;
    logic [31:0]   hold_inst_q, hold_inst_d;
    logic          push;
    logic          pop;

    assign ifu_instrom_addr = pc_q;
    assign ifu_instrom_ren  = !rst && !ex_ifu_redirect && (count_q < DEPTH_C);
    assign ifu_id_valid     = (count_q != '0);
    // When empty, the outputs replay the last head shown so decode never sees stale slots.
    assign ifu_id_pc        = ifu_id_valid ? mem_pc_q[rd_ptr_q]   : hold_pc_q;
    assign ifu_id_inst      = ifu_id_valid ? mem_inst_q[rd_ptr_q] : hold_inst_q;

    assign push = ifu_instrom_ren;
    assign pop  = ifu_id_valid && id_ifu_ready;

    always_comb begin
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_pc_d    = mem_pc_q;
        mem_inst_d  = mem_inst_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;

        if (ifu_id_valid) begin
            hold_pc_d   = mem_pc_q[rd_ptr_q];
            hold_inst_d = mem_inst_q[rd_ptr_q];
        end

        if (ex_ifu_redirect) begin
            pc_d     = {ex_ifu_target[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_pc_d[wr_ptr_q]   = pc_q;
                mem_inst_d[wr_ptr_q] = instrom_ifu_data;
                wr_ptr_d             = wr_ptr_q + PTR_ONE;
                pc_d                 = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= '0;
                mem_inst_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            mem_pc_q    <= mem_pc_d;
            mem_inst_q  <= mem_inst_d;
        end
    end
endmodule

// File: tb/tb_ysyx_24090013_ifu.sv
// Bench for the fetch unit: directed scenarios followed by random traffic, checked against a queue model.
module tb_ysyx_24090013_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_instrom_addr;
    logic        ifu_instrom_ren;
    logic [31:0] instrom_ifu_data;
    logic        ifu_id_valid;
    logic [31:0] ifu_id_inst;
    logic [31:0] ifu_id_pc;
    logic        id_ifu_ready;
    logic        ex_ifu_redirect;
    logic [31:0] ex_ifu_target;

    ysyx_24090013_ifu #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .ifu_instrom_addr (ifu_instrom_addr),
        .ifu_instrom_ren  (ifu_instrom_ren),
        .instrom_ifu_data (instrom_ifu_data),
        .ifu_id_valid     (ifu_id_valid),
        .ifu_id_inst      (ifu_id_inst),
        .ifu_id_pc        (ifu_id_pc),
        .id_ifu_ready     (id_ifu_ready),
        .ex_ifu_redirect  (ex_ifu_redirect),
        .ex_ifu_target    (ex_ifu_target)
    );

    always #5 clk = ~clk;

    // ROM contents: each word is its address scrambled with a fixed pattern.
    assign instrom_ifu_data = ifu_instrom_addr ^ 32'hA5A5_A5A5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_inst;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc        = RESET_PC;
        m_last_pc   = '0;
        m_last_inst = '0;
    endtask

    // One clock cycle: drive inputs on the falling edge, check outputs, then advance the model.
    task automatic cycle(input logic rdy, input logic rd, input logic [31:0] tgt);
        logic exp_ren;
        logic do_pop;
        @(negedge clk);
        rst             = 1'b0;
        id_ifu_ready    = rdy;
        ex_ifu_redirect = rd;
        ex_ifu_target   = tgt;
        #1;
        exp_ren = !rd && (mq.size() < DEPTH);
        chk("ren",   32'(ifu_instrom_ren), 32'(exp_ren));
        chk("addr",  ifu_instrom_addr, m_pc);
        chk("valid", 32'(ifu_id_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("head_pc",   ifu_id_pc,   mq[0].pc);
            chk("head_inst", ifu_id_inst, mq[0].inst);
            m_last_pc   = mq[0].pc;
            m_last_inst = mq[0].inst;
        end else begin
            chk("hold_pc",   ifu_id_pc,   m_last_pc);
            chk("hold_inst", ifu_id_inst, m_last_inst);
        end
        do_pop = (mq.size() != 0) && rdy;
        if (rd) begin
            mq.delete();
            m_pc = tgt & ~32'd3;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (exp_ren) begin
                mq.push_back('{pc: m_pc, inst: m_pc ^ 32'hA5A5_A5A5});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Raise reset between edges and confirm the outputs clear without waiting for a clock.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ifu_id_valid), 32'd0);
        chk("arst_ren",   32'(ifu_instrom_ren), 32'd0);
        chk("arst_addr",  ifu_instrom_addr, RESET_PC);
        chk("arst_pc",    ifu_id_pc, 32'd0);
        chk("arst_inst",  ifu_id_inst, 32'd0);
        model_reset();
    endtask

    initial begin
        rst             = 1'b1;
        id_ifu_ready    = 1'b0;
        ex_ifu_redirect = 1'b0;
        ex_ifu_target   = '0;
        model_reset();
        #2;
        chk("rst_valid", 32'(ifu_id_valid), 32'd0);
        chk("rst_ren",   32'(ifu_instrom_ren), 32'd0);
        chk("rst_addr",  ifu_instrom_addr, RESET_PC);
        chk("rst_pc",    ifu_id_pc, 32'd0);
        chk("rst_inst",  ifu_id_inst, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);      // streaming
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);      // backpressure
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);      // fill, then flush
        cycle(1'b0, 1'b1, 32'h8000_0103);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h8000_0200);                       // redirect with pop
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);                       // wrap-around
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);      // two queued, then reset
        async_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, $urandom); // held redirect
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) async_reset();
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
